// File: rtl/rfm_pkg.sv
// rtl/rfm_pkg.sv - shared types and constants for the rfm_regfile register file
package rfm_pkg;

  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int NREGS = 16;

  typedef logic [WIDTH-1:0] rfm_word_t;
  typedef logic [AW-1:0]    rfm_addr_t;

  // True when a read port should see the in-flight write data (bypass builds only)
  function automatic logic rfm_bypass_hit(input rfm_addr_t raddr, input rfm_addr_t waddr,
                                          input logic we, input logic resetn);
    return we && resetn && (raddr == waddr);
  endfunction

endpackage

// File: rtl/rfm_rdport.sv
// rtl/rfm_rdport.sv - one combinational read mux over the register array
module rfm_rdport
  import rfm_pkg::*;
#(
  parameter int WIDTH = rfm_pkg::WIDTH,
  parameter int AW    = rfm_pkg::AW
) (
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] regs [2**AW],
  output logic [WIDTH-1:0] word
);

  assign word = regs[addr];

endmodule

// File: rtl/rfm_regfile.sv
// rtl/rfm_regfile.sv - 16x32 register file, 3 read + 1 debug read, 1 write; option RFM_BYPASS_EN
module rfm_regfile
  import rfm_pkg::*;
#(
  parameter int WIDTH = rfm_pkg::WIDTH,
  parameter int AW    = rfm_pkg::AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rd,
  output logic [WIDTH-1:0] da,
  output logic [WIDTH-1:0] db,
  output logic [WIDTH-1:0] dd,
  input  logic [AW-1:0]    tr,
  output logic [WIDTH-1:0] tdata
);

  localparam int N = 2**AW;

  logic [WIDTH-1:0] regs [N];
  logic [WIDTH-1:0] ra_word, rb_word, rd_word, tr_word;

  // Reset wins over a simultaneous write; R0 is an ordinary register
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[rd] <= din;
    end
  end

  rfm_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_a (.addr(ra), .regs(regs), .word(ra_word));
  rfm_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_b (.addr(rb), .regs(regs), .word(rb_word));
  rfm_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_d (.addr(rd), .regs(regs), .word(rd_word));
  rfm_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_t (.addr(tr), .regs(regs), .word(tr_word));

`ifdef RFM_BYPASS_EN
  // Write-first: a port addressing rd sees din in the same cycle as the write
  always_comb begin
    da    = (wen && reset && ra == rd) ? din : ra_word;
    db    = (wen && reset && rb == rd) ? din : rb_word;
    dd    = (wen && reset)             ? din : rd_word;
    tdata = (wen && reset && tr == rd) ? din : tr_word;
  end
`else
  assign da    = ra_word;
  assign db    = rb_word;
  assign dd    = rd_word;
  assign tdata = tr_word;
`endif

endmodule

// File: tb/tb_rfm_regfile.sv
// tb/tb_rfm_regfile.sv - directed self-checking bench for rfm_regfile
module tb_rfm_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        wen;
  logic [3:0]  ra, rb, rd, tr;
  logic [31:0] da, db, dd, tdata;

  int errors = 0;
  int checks = 0;

`ifdef RFM_BYPASS_EN
  localparam logic [31:0] RDW_EXP = 32'h0000_0022;
`else
  localparam logic [31:0] RDW_EXP = 32'h0000_0011;
`endif

  rfm_regfile dut (
    .clk(clk), .reset(reset), .din(din), .wen(wen),
    .ra(ra), .rb(rb), .rd(rd),
    .da(da), .db(db), .dd(dd),
    .tr(tr), .tdata(tdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; wen = 1'b0; din = '0;
    ra = '0; rb = '0; rd = '0; tr = '0;
    tick();

    // Preload R3, then reset clears it
    reset = 1'b1; wen = 1'b1; rd = 4'd3; din = 32'h1234_5678;
    tick();
    wen = 1'b0; ra = 4'd3; #1;
    chk("preload_r3", da, 32'h1234_5678);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(i); rd = 4'(i); tr = 4'(i); #1;
      chk("reset_da", da, 32'h0);
      chk("reset_db", db, 32'h0);
      chk("reset_dd", dd, 32'h0);
      chk("reset_tdata", tdata, 32'h0);
    end

    // Write every register, then read back on all ports
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; rd = 4'(i); din = 32'hA5A5_0000 + i;
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i); rd = 4'((i + 3) % 16); tr = 4'((i + 7) % 16); #1;
      chk("wr_da", da, 32'hA5A5_0000 + i);
      chk("wr_db", db, 32'hA5A5_0000 + (15 - i));
      chk("wr_dd", dd, 32'hA5A5_0000 + ((i + 3) % 16));
      chk("wr_tdata", tdata, 32'hA5A5_0000 + ((i + 7) % 16));
    end

    // Same register on every port
    ra = 4'd9; rb = 4'd9; rd = 4'd9; tr = 4'd9; #1;
    chk("same_da", da, 32'hA5A5_0009);
    chk("same_db", db, 32'hA5A5_0009);
    chk("same_dd", dd, 32'hA5A5_0009);
    chk("same_tdata", tdata, 32'hA5A5_0009);

    // Write disable holds R5
    wen = 1'b0; rd = 4'd5; din = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    chk("wen0_r5", dd, 32'hA5A5_0005);
    ra = 4'd0; #1;
    chk("wen0_r0", da, 32'hA5A5_0000);

    // Read-during-write on R7
    wen = 1'b1; rd = 4'd7; din = 32'h0000_0011;
    tick();
    din = 32'h0000_0022; ra = 4'd7; tr = 4'd7; rb = 4'd6; #1;
    chk("rdw_da_pre", da, RDW_EXP);
    chk("rdw_tdata_pre", tdata, RDW_EXP);
    chk("rdw_db_other", db, 32'hA5A5_0006);
    tick();
    wen = 1'b0; #1;
    chk("rdw_da_post", da, 32'h0000_0022);
    chk("rdw_tdata_post", tdata, 32'h0000_0022);

    // Full-width data stored verbatim in R0
    wen = 1'b1; rd = 4'd0; din = 32'h8000_0001;
    tick();
    wen = 1'b0; ra = 4'd0; #1;
    chk("verbatim_r0", da, 32'h8000_0001);

    // Reset pulse without a rising edge does nothing
    reset = 1'b0; #2; reset = 1'b1; #1;
    chk("glitch_r0", da, 32'h8000_0001);
    tick();
    chk("glitch_r0_edge", da, 32'h8000_0001);

    // Reset has priority over a write
    reset = 1'b0; wen = 1'b1; rd = 4'd2; din = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1; wen = 1'b0; ra = 4'd0; tr = 4'd7; #1;
    chk("rstpri_r2", dd, 32'h0);
    chk("rstpri_r0", da, 32'h0);
    chk("rstpri_r7", tdata, 32'h0);

    // Idle address sweep with wrap 15 -> 0
    din = '0; rd = 4'd0; wen = 1'b0; ra = 4'd0;
    for (int i = 0; i < 18; i++) begin
      #5;
      chk("sweep_da", da, 32'h0);
      ra = ra + 4'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
